// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bus between the operand stage and alu_seq.
interface alu_seq_if #(parameter int WIDTH = 32);
  localparam int SW = $clog2(WIDTH);
  logic             In_valid;
  logic             In_ready;
  logic [WIDTH-1:0] Src1;
  logic [WIDTH-1:0] Src2;
  logic [SW-1:0]    Shamt;
  logic [5:0]       Funct;
  logic             Out_valid;
  logic             Out_ready;
  logic [WIDTH-1:0] Result;
  logic [WIDTH-1:0] Hi;
  logic             Zero;
  logic             Carry;
  modport master (output In_valid, Src1, Src2, Shamt, Funct, Out_ready,
                  input  In_ready, Out_valid, Result, Hi, Zero, Carry);
  modport slave  (input  In_valid, Src1, Src2, Shamt, Funct, Out_ready,
                  output In_ready, Out_valid, Result, Hi, Zero, Carry);
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshake; define ALU_MULT_EN to
// build the iterative shift-add MULTU (otherwise MULTU is unsupported, Hi = 0).
module alu_seq #(parameter int WIDTH = 32) (
  input  logic clk,
  input  logic rst_n,
  alu_seq_if.slave bus
);
  localparam int SW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, MUL, OUT} state_t;
  state_t state, next;
  logic [WIDTH-1:0] res_c;
  logic carry_c, accept, is_mul, mul_done;
  logic [WIDTH:0] add_r, sub_r, sll_r, srl_r;
  assign bus.In_ready  = state == IDLE;
  assign bus.Out_valid = state == OUT;
  assign accept = bus.In_valid && state == IDLE;
  // srl_r keeps one guard bit below the result so bit 0 is the last bit shifted out
  assign add_r = {1'b0, bus.Src1} + {1'b0, bus.Src2};
  assign sub_r = {1'b0, bus.Src1} - {1'b0, bus.Src2};
  assign sll_r = {1'b0, bus.Src1} << bus.Shamt;
  assign srl_r = {bus.Src1, 1'b0} >> bus.Shamt;
  always_comb begin
    res_c   = '0;
    carry_c = 1'b0;
    case (bus.Funct)
      6'b001001: {carry_c, res_c} = add_r;
      6'b001010: {carry_c, res_c} = sub_r;
      6'b010001: res_c = bus.Src1 & bus.Src2;
      6'b100001: {carry_c, res_c} = sll_r;
      6'b100010: {res_c, carry_c} = srl_r;
      default: ;
    endcase
  end
`ifdef ALU_MULT_EN
  localparam logic [SW:0] LAST = (SW+1)'(WIDTH - 1);
  logic [SW:0] cnt;
  logic [WIDTH-1:0] mcand, hi;
  logic [2*WIDTH-1:0] prod, prod_n;
  logic [WIDTH:0] psum;
  assign is_mul   = bus.Funct == 6'b011001;
  assign mul_done = state == MUL && cnt == LAST;
  assign psum     = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{prod[0]}} & mcand};
  assign prod_n   = {psum, prod[WIDTH-1:1]};
  assign bus.Hi   = hi;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      mcand <= '0;
      prod  <= '0;
    end else if (accept && is_mul) begin
      cnt   <= '0;
      mcand <= bus.Src1;
      prod  <= {{WIDTH{1'b0}}, bus.Src2};
    end else if (state == MUL) begin
      cnt  <= cnt + 1'b1;
      prod <= prod_n;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.Result <= '0;
      hi         <= '0;
      bus.Carry  <= 1'b0;
      bus.Zero   <= 1'b1;
    end else if (accept && !is_mul) begin
      bus.Result <= res_c;
      hi         <= '0;
      bus.Carry  <= carry_c;
      bus.Zero   <= ~|res_c;
    end else if (mul_done) begin
      bus.Result <= prod_n[WIDTH-1:0];
      hi         <= prod_n[2*WIDTH-1:WIDTH];
      bus.Carry  <= |prod_n[2*WIDTH-1:WIDTH];
      bus.Zero   <= ~|prod_n;
    end
  end
`else
  assign is_mul   = 1'b0;
  assign mul_done = 1'b0;
  assign bus.Hi   = '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.Result <= '0;
      bus.Carry  <= 1'b0;
      bus.Zero   <= 1'b1;
    end else if (accept) begin
      bus.Result <= res_c;
      bus.Carry  <= carry_c;
      bus.Zero   <= ~|res_c;
    end
  end
`endif
  always_comb begin
    next = state == IDLE ? (accept ? (is_mul ? MUL : OUT) : IDLE) :
           state == MUL  ? (mul_done ? OUT : MUL) :
           state == OUT  ? (bus.Out_ready ? IDLE : OUT) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= next;
  end
endmodule
